// File: rtl/regfile_32x64.sv
// LEGv8 integer register file: 2**ADDR_W x DATA_W, hardwired zero register,
// two combinational read ports with optional same-cycle write forwarding, plus a debug read port.
module regfile_32x64 #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic              wr_en;
  logic              bypass_en;

  // reg_write gates everything first, so an unknown write_reg with reg_write=0 cannot update.
  assign wr_en     = reg_write && (write_reg != ZERO_ADDR);
  assign bypass_en = (BYPASS != 0) && reg_write && rst_n;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[write_reg] = write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Priority per port: zero register, then forwarded write, then stored value.
  always_comb begin
    read_data1 = mem_q[read_reg1];
    if (bypass_en && (write_reg == read_reg1)) read_data1 = write_data;
    if (read_reg1 == ZERO_ADDR) read_data1 = '0;
  end

  always_comb begin
    read_data2 = mem_q[read_reg2];
    if (bypass_en && (write_reg == read_reg2)) read_data2 = write_data;
    if (read_reg2 == ZERO_ADDR) read_data2 = '0;
  end

  always_comb begin
    dbg_data = mem_q[dbg_addr];
    if (dbg_addr == ZERO_ADDR) dbg_data = '0;
  end

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: one forwarding and one non-forwarding instance share stimulus.
module tb_regfile_32x64;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] read_reg1 = '0;
  logic [AW-1:0] read_reg2 = '0;
  logic [AW-1:0] write_reg = '0;
  logic [DW-1:0] write_data = '0;
  logic          reg_write = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] rd1_b, rd2_b, dbg_b;
  logic [DW-1:0] rd1_n, rd2_n, dbg_n;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [32];

  typedef struct {
    logic [AW-1:0] r1, r2, d;
    logic [DW-1:0] e1, e2, ed;
  } vec_t;
  vec_t vecs [32];

  // clock / reset
  always #50 clk = ~clk;

  regfile_32x64 #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(rd1_b), .read_data2(rd2_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  regfile_32x64 #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(rd1_n), .read_data2(rd2_n), .dbg_addr(dbg_addr), .dbg_data(dbg_n)
  );

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return (a == 5'd31) ? '0 : model[a];
  endfunction

  // scoreboard
  task automatic pop_cmp(input string nm, input logic [DW-1:0] act);
    logic [DW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got %h with nothing expected", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  endtask

  task automatic probe(input string nm,
                       input logic [DW-1:0] b1, b2, bd, n1, n2, nd);
    exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(bd);
    exp_q.push_back(n1); exp_q.push_back(n2); exp_q.push_back(nd);
    #1;
    pop_cmp({nm, " byp.rd1"}, rd1_b);
    pop_cmp({nm, " byp.rd2"}, rd2_b);
    pop_cmp({nm, " byp.dbg"}, dbg_b);
    pop_cmp({nm, " nob.rd1"}, rd1_n);
    pop_cmp({nm, " nob.rd2"}, rd2_n);
    pop_cmp({nm, " nob.dbg"}, dbg_n);
  endtask

  // driver tasks
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    reg_write = 1'b1; write_reg = a; write_data = d;
    @(posedge clk);
    if (a != 5'd31) model[a] = d;
    #1 reg_write = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 32; i++) begin
      vecs[i].r1 = AW'(i);
      vecs[i].r2 = AW'($urandom_range(0, 31));
      vecs[i].d  = AW'(31 - i);
      vecs[i].e1 = model_rd(vecs[i].r1);
      vecs[i].e2 = model_rd(vecs[i].r2);
      vecs[i].ed = model_rd(vecs[i].d);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      reg_write = 1'b0;
      read_reg1 = vecs[i].r1; read_reg2 = vecs[i].r2; dbg_addr = vecs[i].d;
      probe($sformatf("%s[%0d]", tag, i), vecs[i].e1, vecs[i].e2, vecs[i].ed,
            vecs[i].e1, vecs[i].e2, vecs[i].ed);
    end
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;

    // reset state
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      read_reg1 = AW'(a); read_reg2 = AW'(30 - a); dbg_addr = AW'(a + 7);
      probe("reset_init", '0, '0, '0, '0, '0, '0);
    end
    rst_n = 1'b1;

    // fill X1..X30, then verify
    for (int i = 1; i <= 30; i++) wr(AW'(i), 64'hA5A5_0000_0000_0000 | DW'(i));
    run_table("fill");

    // asynchronous reset pulse between clock edges
    @(negedge clk);
    #1 rst_n = 1'b0;
    for (int a = 0; a < 32; a++) begin
      read_reg1 = AW'(a); read_reg2 = AW'(31 - a); dbg_addr = AW'(a);
      probe("reset_pulse", '0, '0, '0, '0, '0, '0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    run_table("post_reset");

    // basic write/read
    wr(5'd5, 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    read_reg1 = 5'd5; read_reg2 = 5'd5; dbg_addr = 5'd5;
    probe("basic", 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'hDEAD_BEEF,
          64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'hDEAD_BEEF);

    // XZR write dropped, reads 0 before and after edge
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd31; write_data = '1;
    read_reg1 = 5'd31; read_reg2 = 5'd31; dbg_addr = 5'd31;
    probe("xzr_pre", '0, '0, '0, '0, '0, '0);
    @(negedge clk);
    probe("xzr_post", '0, '0, '0, '0, '0, '0);
    reg_write = 1'b0;
    read_reg1 = 5'd5;
    probe("xzr_x5", 64'hDEAD_BEEF, '0, '0, 64'hDEAD_BEEF, '0, '0);

    // forwarding vs. stored value around the edge
    wr(5'd7, 64'h11);
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd7; write_data = 64'h22;
    read_reg1 = 5'd7; read_reg2 = 5'd7; dbg_addr = 5'd7;
    probe("bypass_pre", 64'h22, 64'h22, 64'h11, 64'h11, 64'h11, 64'h11);
    @(negedge clk);
    model[7] = 64'h22;
    probe("bypass_post", 64'h22, 64'h22, 64'h22, 64'h22, 64'h22, 64'h22);
    reg_write = 1'b0;

    // writes blocked while reset is held
    @(negedge clk);
    rst_n = 1'b0;
    reg_write = 1'b1; write_reg = 5'd3; write_data = 64'h55;
    read_reg1 = 5'd3; read_reg2 = 5'd3; dbg_addr = 5'd3;
    for (int i = 0; i < 32; i++) model[i] = '0;
    probe("rst_hold", '0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    probe("rst_hold_edges", '0, '0, '0, '0, '0, '0);
    rst_n = 1'b1;
    probe("rst_release", 64'h55, 64'h55, '0, '0, '0, '0);
    @(negedge clk);
    model[3] = 64'h55;
    probe("rst_first_write", 64'h55, 64'h55, 64'h55, 64'h55, 64'h55, 64'h55);
    reg_write = 1'b0;

    // Reg2Loc: read_reg2 toggles with no clock edge
    wr(5'd9, 64'h100);
    wr(5'd10, 64'h200);
    @(negedge clk);
    read_reg1 = 5'd9; dbg_addr = 5'd10;
    for (int k = 0; k < 6; k++) begin
      read_reg2 = (k % 2 == 1) ? 5'd10 : 5'd9;
      probe($sformatf("reg2loc[%0d]", k), 64'h100, model_rd(read_reg2), 64'h200,
            64'h100, model_rd(read_reg2), 64'h200);
    end

    // unknown write address with writes disabled
    @(negedge clk);
    reg_write = 1'b0; write_reg = 'x; write_data = {$urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    write_reg = '0;
    run_table("x_safe");

    // random writes, then full sweep
    for (int n = 0; n < 12; n++)
      wr(AW'($urandom_range(0, 31)), {$urandom, $urandom});
    run_table("random");

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
